// File: rtl/led_word_capture.sv
// led_word_capture: per-pixel WS2812 word capture with tap offset, passthrough, short-frame and forwarded-bit count
module led_word_capture #(
  parameter int DATA_W = 24,
  parameter int TAP_INDEX = 0,
  parameter int CNT_W = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_bit_valid,
  input  logic              i_bit,
  input  logic              i_treset,
  output logic [DATA_W-1:0] o_led_data,
  output logic              o_led_valid,
  output logic              o_passthru_en,
  output logic              o_short_frame,
  output logic [CNT_W-1:0]  o_fwd_cnt
);
  localparam int BW = $clog2(DATA_W);
  localparam int WW = (TAP_INDEX > 0) ? $clog2(TAP_INDEX + 1) : 1;
  typedef enum logic [1:0] {SKIP, CAPTURE, PASSTHRU} state_t;
  localparam state_t INIT = (TAP_INDEX > 0) ? SKIP : CAPTURE;
  state_t state, state_nx;
  logic [DATA_W-1:0] sr;
  logic [BW-1:0] bit_cnt;
  logic [WW-1:0] word_cnt, word_inc;
  logic take, last_bit;
  assign take = i_bit_valid && !i_treset;
  assign last_bit = bit_cnt == BW'(DATA_W - 1);
  assign word_inc = word_cnt + 1'b1;
  assign o_passthru_en = state != CAPTURE;
  always_comb begin
    state_nx = state;
    if (i_treset)
      state_nx = INIT;
    else if (take && last_bit)
      state_nx = (state == SKIP && word_inc == WW'(TAP_INDEX)) ? CAPTURE :
                 (state == CAPTURE) ? PASSTHRU : state;
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) state <= INIT;
    else state <= state_nx;
  // a treset landing on the final bit of a complete word is not a truncated frame
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sr <= '0;
      bit_cnt <= '0;
      word_cnt <= '0;
      o_led_data <= '0;
      o_led_valid <= 1'b0;
      o_short_frame <= 1'b0;
      o_fwd_cnt <= '0;
    end else begin
      o_led_valid <= take && state == CAPTURE && last_bit;
      o_short_frame <= i_treset && state == CAPTURE && bit_cnt != '0 && !(i_bit_valid && last_bit);
      if (i_treset) begin
        sr <= '0;
        bit_cnt <= '0;
        word_cnt <= '0;
        o_fwd_cnt <= '0;
      end else if (i_bit_valid) begin
        if (state != PASSTHRU) bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        if (state == SKIP && last_bit) word_cnt <= word_inc;
        if (state == CAPTURE) sr <= {sr[DATA_W-2:0], i_bit};
        if (state == CAPTURE && last_bit) o_led_data <= {sr[DATA_W-2:0], i_bit};
        if (state != CAPTURE && o_fwd_cnt != '1) o_fwd_cnt <= o_fwd_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_led_word_capture.sv
// tb_led_word_capture: directed checks of capture, tap skip, short frame, saturation and async reset
module tb_led_word_capture;
  logic clk = 1'b0, rst_n = 1'b0, bv = 1'b0, bt = 1'b0, tr = 1'b0;
  logic [23:0] d0, d2, d4;
  logic [31:0] d32;
  logic v0, p0, s0, v2, p2, s2, v32, p32, s32, v4, p4, s4;
  logic [15:0] f0, f2, f32;
  logic [3:0] f4;
  int n_cmp = 0, n_err = 0;
  int nv0 = 0, ns0 = 0, nv2 = 0, nv32 = 0, ns32 = 0;
  int bv0, bs0, bv2, bv32, bs32;

  always #5 clk = ~clk;

  led_word_capture #(.DATA_W(24), .TAP_INDEX(0), .CNT_W(16)) u0 (.i_clk(clk), .i_reset_n(rst_n),
    .i_bit_valid(bv), .i_bit(bt), .i_treset(tr), .o_led_data(d0), .o_led_valid(v0),
    .o_passthru_en(p0), .o_short_frame(s0), .o_fwd_cnt(f0));
  led_word_capture #(.DATA_W(24), .TAP_INDEX(2), .CNT_W(16)) u2 (.i_clk(clk), .i_reset_n(rst_n),
    .i_bit_valid(bv), .i_bit(bt), .i_treset(tr), .o_led_data(d2), .o_led_valid(v2),
    .o_passthru_en(p2), .o_short_frame(s2), .o_fwd_cnt(f2));
  led_word_capture #(.DATA_W(32), .TAP_INDEX(0), .CNT_W(16)) u32 (.i_clk(clk), .i_reset_n(rst_n),
    .i_bit_valid(bv), .i_bit(bt), .i_treset(tr), .o_led_data(d32), .o_led_valid(v32),
    .o_passthru_en(p32), .o_short_frame(s32), .o_fwd_cnt(f32));
  led_word_capture #(.DATA_W(24), .TAP_INDEX(0), .CNT_W(4)) u4 (.i_clk(clk), .i_reset_n(rst_n),
    .i_bit_valid(bv), .i_bit(bt), .i_treset(tr), .o_led_data(d4), .o_led_valid(v4),
    .o_passthru_en(p4), .o_short_frame(s4), .o_fwd_cnt(f4));

  always @(negedge clk) begin
    if (v0) nv0 <= nv0 + 1;
    if (s0) ns0 <= ns0 + 1;
    if (v2) nv2 <= nv2 + 1;
    if (v32) nv32 <= nv32 + 1;
    if (s32) ns32 <= ns32 + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    bv = 1'b1;
    bt = b;
    @(negedge clk);
    bv = 1'b0;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_range(input logic [63:0] v, input int hi, input int lo, input bit gaps);
    for (int i = hi; i >= lo; i--) begin
      drive_bit(v[i]);
      if (gaps && i > lo) idle(i % 3);
    end
  endtask

  task automatic treset_pulse();
    @(negedge clk);
    tr = 1'b1;
    @(negedge clk);
    tr = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_data", d0, 0);
    chk("rst_valid", v0, 0);
    chk("rst_passthru", p0, 0);
    chk("rst_short", s0, 0);
    chk("rst_fwd", f0, 0);
    chk("rst_passthru_tap2", p2, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // capture with irregular gaps, then forward two words
    send_range(64'hA5C33C, 23, 1, 1'b1);
    chk("t1_pre_passthru", p0, 0);
    bv0 = nv0;
    drive_bit(1'b0);
    chk("t1_data", d0, 24'hA5C33C);
    chk("t1_valid", v0, 1);
    chk("t1_passthru", p0, 1);
    idle(1);
    chk("t1_valid_low", v0, 0);
    chk("t1_valid_once", nv0 - bv0, 1);
    send_range(64'h0F0F0F, 23, 0, 1'b0);
    send_range(64'hF0F0F0, 23, 0, 1'b0);
    chk("t1_fwd48", f0, 48);
    chk("t1_data_hold", d0, 24'hA5C33C);
    bs0 = ns0;
    treset_pulse();
    chk("t1_tr_passthru", p0, 0);
    chk("t1_tr_fwd", f0, 0);
    chk("t1_tr_data", d0, 24'hA5C33C);
    idle(1);
    chk("t1_tr_no_short", ns0 - bs0, 0);

    // tap index 2: two words forwarded, third captured
    do_reset();
    bv2 = nv2;
    send_range(64'h111111, 23, 0, 1'b0);
    chk("t2_w1_passthru", p2, 1);
    chk("t2_w1_fwd", f2, 24);
    send_range(64'h222222, 23, 0, 1'b0);
    chk("t2_w2_passthru", p2, 0);
    chk("t2_w2_fwd", f2, 48);
    send_range(64'h333333, 23, 1, 1'b0);
    chk("t2_w3_passthru", p2, 0);
    drive_bit(1'b1);
    chk("t2_data", d2, 24'h333333);
    chk("t2_valid", v2, 1);
    chk("t2_passthru_after", p2, 1);
    chk("t2_fwd_after", f2, 48);
    idle(1);
    chk("t2_valid_once", nv2 - bv2, 1);

    // u0 captured 0x111111 from the same stream; now truncate a frame
    chk("t3_prev_data", d0, 24'h111111);
    treset_pulse();
    bs0 = ns0;
    bv0 = nv0;
    send_range(64'hABCDEF, 23, 14, 1'b0);
    treset_pulse();
    chk("t3_short", s0, 1);
    chk("t3_data_hold", d0, 24'h111111);
    idle(1);
    chk("t3_short_low", s0, 0);
    chk("t3_short_once", ns0 - bs0, 1);
    chk("t3_no_valid", nv0 - bv0, 0);
    send_range(64'h00FF00, 23, 0, 1'b0);
    chk("t3_data_new", d0, 24'h00FF00);
    chk("t3_valid", v0, 1);

    // 32-bit word, then treset coincident with the final bit
    do_reset();
    send_range(64'hDEADBEEF, 31, 0, 1'b0);
    chk("t4_data", d32, 32'hDEADBEEF);
    chk("t4_valid", v32, 1);
    treset_pulse();
    chk("t4_tr_passthru", p32, 0);
    bv32 = nv32;
    bs32 = ns32;
    send_range(64'h12345678, 31, 1, 1'b0);
    @(negedge clk);
    bv = 1'b1;
    bt = 1'b0;
    tr = 1'b1;
    @(negedge clk);
    bv = 1'b0;
    tr = 1'b0;
    #1;
    chk("t4_co_valid", v32, 0);
    chk("t4_co_short", s32, 0);
    chk("t4_co_data", d32, 32'hDEADBEEF);
    chk("t4_co_passthru", p32, 0);
    idle(1);
    chk("t4_co_no_valid", nv32 - bv32, 0);
    chk("t4_co_no_short", ns32 - bs32, 0);
    send_range(64'hCAFEF00D, 31, 0, 1'b0);
    chk("t4_next_data", d32, 32'hCAFEF00D);

    // 4-bit forwarded counter saturates
    do_reset();
    send_range(64'hABCDEF, 23, 0, 1'b0);
    send_range(64'h3FFF, 13, 0, 1'b0);
    chk("t5_fwd14", f4, 14);
    send_range(64'h2A, 5, 0, 1'b0);
    chk("t5_fwd_sat", f4, 15);

    // asynchronous reset mid-capture
    do_reset();
    bv0 = nv0;
    bs0 = ns0;
    send_range(64'h123456, 23, 12, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_data", d0, 0);
    chk("t6_valid", v0, 0);
    chk("t6_passthru", p0, 0);
    chk("t6_short", s0, 0);
    chk("t6_fwd", f0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_no_pulses", (nv0 - bv0) + (ns0 - bs0), 0);
    send_range(64'h123456, 23, 0, 1'b0);
    chk("t6_data_new", d0, 24'h123456);
    chk("t6_valid_new", v0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
